// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, CPOL/CPHA modes, runtime SCK divider, NUM_SS selects.
// Optional macro SPI_MASTER_PARAM_LSB_FIRST_EN adds i_lsb_first for LSB-first bit order.
module spi_master_param #(
   parameter  int DATA_W = 8,
   parameter  int NUM_SS = 1,
   parameter  int DIV_W  = 8,
   localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,        // asynchronous, active-low
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [SS_W-1:0]   i_ss_sel,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic [DIV_W-1:0]  i_clk_div,
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
   input  logic              i_lsb_first,
`endif
   input  logic              i_miso,
   output logic              o_mosi,
   output logic              o_sck,
   output logic [NUM_SS-1:0] o_ss,
   output logic [DATA_W-1:0] o_rd,
   output logic              o_rdy,
   output logic              o_busy
);

   localparam int HP_W = $clog2(2 * DATA_W);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   state_t              r_state;
   logic                r_arm;
   logic                r_cpol, r_cpha, r_lsb;
   logic [DIV_W-1:0]    r_div, r_cnt;
   logic [HP_W-1:0]     r_hp;
   logic [SS_W-1:0]     r_sel;
   logic [DATA_W-1:0]   r_tx, r_rx, r_rd;
   logic [NUM_SS-1:0]   r_ss;
   logic                r_mosi, r_sck, r_rdy, r_busy;

   logic                w_lsb_in;
   logic [31:0]         w_sel_ext;
   logic                w_sel_ok;
   logic                w_hp_end;
   logic                w_shift;
   logic                w_tx_bit;
   logic [DATA_W-1:0]   w_tx_next, w_rx_next;
   logic [NUM_SS-1:0]   w_ss_low;

`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
   assign w_lsb_in = i_lsb_first;
`else
   assign w_lsb_in = 1'b0;
`endif

   assign w_sel_ext = {{(32-SS_W){1'b0}}, i_ss_sel};
   assign w_sel_ok  = (w_sel_ext < NUM_SS);
   assign w_hp_end  = (r_cnt == r_div);
   // Even half-period index ends on the leading SCK edge.
   assign w_shift   = r_hp[0] ? ~r_cpha : r_cpha;
   assign w_tx_bit  = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
   assign w_tx_next = r_lsb ? (r_tx >> 1) : (r_tx << 1);
   assign w_rx_next = r_lsb ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};
   assign w_ss_low  = ~(NUM_SS'(1) << r_sel);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_arm   <= 1'b0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_hp    <= '0;
         r_sel   <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rd    <= '0;
         r_ss    <= '1;
         r_mosi  <= 1'b0;
         r_sck   <= 1'b0;
         r_rdy   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start && w_sel_ok) begin
                  r_tx    <= i_wd;
                  r_sel   <= i_ss_sel;
                  r_cpol  <= i_cpol;
                  r_cpha  <= i_cpha;
                  r_div   <= i_clk_div;
                  r_lsb   <= w_lsb_in;
                  r_cnt   <= '0;
                  r_arm   <= 1'b1;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               // First SETUP cycle only asserts the select; the H-cycle setup count follows.
               if (r_arm) begin
                  r_arm  <= 1'b0;
                  r_busy <= 1'b1;
                  r_ss   <= w_ss_low;
                  r_sck  <= r_cpol;
                  r_cnt  <= '0;
                  if (!r_cpha) begin
                     r_mosi <= w_tx_bit;
                     r_tx   <= w_tx_next;
                  end
               end else if (w_hp_end) begin
                  r_cnt   <= '0;
                  r_hp    <= '0;
                  r_state <= XFER;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            XFER: begin
               if (w_hp_end) begin
                  r_cnt <= '0;
                  r_sck <= ~r_sck;
                  r_hp  <= r_hp + 1'b1;
                  if (w_shift) begin
                     r_mosi <= w_tx_bit;
                     r_tx   <= w_tx_next;
                  end else begin
                     r_rx <= w_rx_next;
                  end
                  if (r_hp == HP_W'(2 * DATA_W - 1)) r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (w_hp_end) begin
                  r_cnt   <= '0;
                  r_ss    <= '1;
                  r_rd    <= r_rx;
                  r_rdy   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_mosi = r_mosi;
   assign o_sck  = r_sck;
   assign o_ss   = r_ss;
   assign o_rd   = r_rd;
   assign o_rdy  = r_rdy;
   assign o_busy = r_busy;

endmodule
